// File: rtl/mult_defs.sv
// Shared definitions for the 32x32 shift-and-add multiplier: FSM encodings,
// iteration count and the unsigned carry-out recovery used after the add step.
package mult_defs;

    localparam int          ITER_COUNT = 32;
    localparam logic [4:0]  LAST_COUNT = 5'(ITER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The adder exposes no carry-out, so rebuild it from the operand and sum MSBs.
    function automatic logic carry_out(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
    endfunction

endpackage

// File: rtl/carry_lookahead_adder_32b.sv
// 32-bit adder built from eight 4-bit lookahead groups with group-level carry chaining.
module carry_lookahead_adder_32b (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        C_in,
    output logic [31:0] S,
    output logic        overflow
);

    // Returns {carry into bit 32, carry into bit 31, sum}.
    function automatic logic [33:0] cla_add(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [31:0] g;
        logic [31:0] p;
        logic [32:0] c;
        logic        grp_g;
        logic        grp_p;
        g    = a & b;
        p    = a ^ b;
        c    = 33'd0;
        c[0] = cin;
        for (int grp = 0; grp < 8; grp++) begin
            grp_g = 1'b0;
            grp_p = 1'b1;
            for (int k = 0; k < 4; k++) begin
                c[grp*4 + k + 1] = g[grp*4 + k] | (p[grp*4 + k] & c[grp*4 + k]);
                grp_g = g[grp*4 + k] | (p[grp*4 + k] & grp_g);
                grp_p = grp_p & p[grp*4 + k];
            end
            // Group carry-out from lookahead terms rather than the last ripple bit.
            c[grp*4 + 4] = grp_g | (grp_p & c[grp*4]);
        end
        return {c[32], c[31], p ^ c[31:0]};
    endfunction

    logic [33:0] w_res;

    assign w_res    = cla_add(A, B, C_in);
    assign S        = w_res[31:0];
    assign overflow = w_res[33] ^ w_res[32];

endmodule

// File: rtl/shift_add_multiplier_32b.sv
// Unsigned 32x32 -> 64 multiplier: one add-and-shift step per cycle, fixed 32 iterations.
module shift_add_multiplier_32b
    import mult_defs::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        ready,
    output logic        done,
    output logic [63:0] P
);

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_mcand;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_count;
    logic        r_done;
    logic [63:0] r_p;
    logic [31:0] w_addend;
    logic [31:0] w_sum;
    logic [31:0] w_hi_next;
    logic [31:0] w_lo_next;
    logic        w_cout;
    logic        w_last;
    logic        w_unused_ovf;

    assign w_addend = r_lo[0] ? r_mcand : 32'd0;

    carry_lookahead_adder_32b u_adder (
        .A        (r_hi),
        .B        (w_addend),
        .C_in     (1'b0),
        .S        (w_sum),
        .overflow (w_unused_ovf)
    );

    assign w_cout    = carry_out(r_hi[31], w_addend[31], w_sum[31]);
    assign w_hi_next = {w_cout, w_sum[31:1]};
    assign w_lo_next = {w_sum[0], r_lo[31:1]};
    assign w_last    = (r_count == LAST_COUNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only looked at while idle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) w_next_state = RUN;
                else       w_next_state = IDLE;
            end
            RUN: begin
                if (w_last) w_next_state = DONE;
                else        w_next_state = RUN;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: operand load, add-and-shift iterations, result capture and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_count <= 5'd0;
            r_p     <= 64'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= A;
                        r_hi    <= 32'd0;
                        r_lo    <= B;
                        r_count <= 5'd0;
                    end else begin
                        r_mcand <= r_mcand;
                        r_hi    <= r_hi;
                        r_lo    <= r_lo;
                        r_count <= r_count;
                    end
                end
                RUN: begin
                    r_hi    <= w_hi_next;
                    r_lo    <= w_lo_next;
                    r_count <= r_count + 5'd1;
                    if (w_last) begin
                        r_p    <= {w_hi_next, w_lo_next};
                        r_done <= 1'b1;
                    end else begin
                        r_p    <= r_p;
                        r_done <= 1'b0;
                    end
                end
                default: begin
                    r_mcand <= r_mcand;
                    r_hi    <= r_hi;
                    r_lo    <= r_lo;
                    r_count <= r_count;
                    r_p     <= r_p;
                end
            endcase
        end
    end

    assign ready = (r_state == IDLE);
    assign done  = r_done;
    assign P     = r_p;

endmodule

// File: tb/tb_shift_add_multiplier_32b.sv
// Scoreboard bench for shift_add_multiplier_32b: directed products, ignored start,
// reset abort and a back-to-back random run against a 64-bit multiply reference.
module tb_shift_add_multiplier_32b;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        ready;
    logic        done;
    logic [63:0] P;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] p;
        int          at;
    } exp_t;

    exp_t q[$];

    shift_add_multiplier_32b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .P     (P)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("product", P, e.p);
                check("latency_edge", 64'(cyc), 64'(e.at));
            end
        end
    end

    // Called at a negedge; returns the index of the accepting rising edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [63:0] expp,
                         input bit push, output int edge_i);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 200 cycles", ready);
        end
        start = 1'b1;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        edge_i = cyc;
        if (push) q.push_back('{expp, edge_i + 32});
        @(negedge clk);
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() != 0 || ready !== 1'b1) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0 || ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got pending=%0d ready=%b expected 0 and 1", q.size(), ready);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int prev;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        start = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done",  64'(done),  64'd0);
        check("rst_p",     P,          64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b1, k);
        wait_idle();
        repeat (3) @(negedge clk);
        check("p_hold", P, 64'h0000_0000_0000_000F);

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, k);
        wait_idle();
        issue(32'h0000_0000, 32'hDEAD_BEEF, 64'h0, 1'b1, k);
        wait_idle();
        issue(32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678, 1'b1, k);
        wait_idle();

        // Start pulses during RUN cycles 5 and 32 must be ignored.
        issue(32'd7, 32'd6, 64'd42, 1'b1, k);
        wait_cyc(k + 4);
        start = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(k + 31);
        start = 1'b1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        check("ignored_ready", 64'(ready), 64'd1);
        repeat (4) @(negedge clk);
        check("ignored_p", P, 64'd42);
        check("ignored_still_idle", 64'(ready), 64'd1);

        // Reset during RUN cycle 10 aborts silently.
        issue(32'd5, 32'd5, 64'd25, 1'b0, k);
        wait_cyc(k + 9);
        rst_n = 1'b0;
        #1;
        check("abort_p",     P,          64'd0);
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_done",  64'(done),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_p_after", P,          64'd0);
        check("abort_ready_after", 64'(ready), 64'd1);
        issue(32'd2, 32'd9, 64'd18, 1'b1, k);
        wait_idle();

        // Back-to-back random operands, each accepted as soon as ready returns.
        prev = 0;
        for (int i = 0; i < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            issue(ra, rb, {32'd0, ra} * {32'd0, rb}, 1'b1, k);
            if (i > 0) check("issue_spacing", 64'(k - prev), 64'd34);
            prev = k;
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
